// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the IF-stage program counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2
    } pc_state_e;

    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] pc_align(input logic [31:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pc_sequencer_pc_inc_comb.sv
// Sequential-fetch incrementer; wraps modulo 2^32.
module pc_inc_comb
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o
);

    assign pc_next_o = pc_i + PC_STEP;

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage PC owner: boot delay, stall hold, EX redirect with parking
// while the instruction memory is busy, and pipeline flush generation.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          BOOT_CYCLES  = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BUSYWAIT,
    input  logic        HAZARD_STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic        FETCH_VALID,
    output logic        FLUSH,
    output logic        MISALIGN,
    output logic [1:0]  STATE
);

    localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);

    pc_state_e     state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fv_q, fv_d;
    logic          flush_q, flush_d;
    logic          mis_q, mis_d;

    logic [31:0]   pc_inc;
    logic [31:0]   tgt_al;
    logic          tgt_mis;

    pc_inc_comb u_inc (
        .pc_i      (pc_q),
        .pc_next_o (pc_inc)
    );

    assign tgt_al  = pc_align(BRANCH_TARGET);
    assign tgt_mis = |BRANCH_TARGET[1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        cnt_d   = '0;
        fv_d    = fv_q;
        flush_d = 1'b0;
        mis_d   = 1'b0;
        case (state_q)
            ST_BOOT: begin
                fv_d = 1'b0;
                pc_d = RESET_VECTOR;
                if (cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                    fv_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (BRANCH_TAKEN) begin
                    flush_d = 1'b1;
                    mis_d   = tgt_mis;
                    if (BUSYWAIT) begin
                        pend_d  = tgt_al;
                        state_d = ST_REDIRECT;
                    end else begin
                        pc_d = tgt_al;
                    end
                end else if (!(BUSYWAIT || HAZARD_STALL)) begin
                    pc_d = pc_inc;
                end
            end
            ST_REDIRECT: begin
                // A newer redirect replaces the parked one.
                if (BRANCH_TAKEN) begin
                    flush_d = 1'b1;
                    mis_d   = tgt_mis;
                    if (BUSYWAIT) begin
                        pend_d = tgt_al;
                    end else begin
                        pc_d    = tgt_al;
                        state_d = ST_RUN;
                    end
                end else if (!BUSYWAIT) begin
                    pc_d    = pend_q;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
                fv_d    = 1'b0;
                pc_d    = RESET_VECTOR;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            pend_q  <= '0;
            cnt_q   <= '0;
            fv_q    <= 1'b0;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            fv_q    <= fv_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
        end
    end

    assign PC          = pc_q;
    assign PC_PLUS4    = pc_inc;
    assign FETCH_VALID = fv_q;
    assign FLUSH       = flush_q;
    assign MISALIGN    = mis_q;
    assign STATE       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and random checks of pc_sequencer against a behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int          BC = 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        BW = 1'b0;
    logic        HS = 1'b0;
    logic        BT = 1'b0;
    logic [31:0] TGT = '0;
    logic [31:0] PC, PC_PLUS4;
    logic        FETCH_VALID, FLUSH, MISALIGN;
    logic [1:0]  STATE;

    int n_cmp = 0;
    int n_bad = 0;

    // model: mode 0 = booting, 1 = running, 2 = redirect parked
    int          m_mode;
    int          m_boot;
    logic [31:0] m_pc, m_pend;
    bit          m_fv, m_fl, m_mis;

    pc_sequencer #(
        .RESET_VECTOR (RV),
        .BOOT_CYCLES  (BC)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .BUSYWAIT      (BW),
        .HAZARD_STALL  (HS),
        .BRANCH_TAKEN  (BT),
        .BRANCH_TARGET (TGT),
        .PC            (PC),
        .PC_PLUS4      (PC_PLUS4),
        .FETCH_VALID   (FETCH_VALID),
        .FLUSH         (FLUSH),
        .MISALIGN      (MISALIGN),
        .STATE         (STATE)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_mode = 0;
        m_boot = 0;
        m_pc   = RV;
        m_pend = '0;
        m_fv   = 0;
        m_fl   = 0;
        m_mis  = 0;
    endtask

    task automatic model_edge();
        if (!RESET) begin
            model_reset();
        end else if (m_mode == 0) begin
            m_fl = 0;
            m_mis = 0;
            m_boot++;
            if (m_boot >= BC) begin
                m_mode = 1;
                m_fv = 1;
                m_pc = RV;
            end
        end else begin
            m_fl = BT;
            m_mis = BT && (TGT % 4 != 0);
            if (BT) begin
                if (!BW) begin
                    m_pc = TGT - (TGT % 4);
                    m_mode = 1;
                end else begin
                    m_pend = TGT - (TGT % 4);
                    m_mode = 2;
                end
            end else if (m_mode == 2) begin
                if (!BW) begin
                    m_pc = m_pend;
                    m_mode = 1;
                end
            end else if (!BW && !HS) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_p4;
        exp_p4 = m_pc + 32'd4;
        cmp({tag, ".pc"}, PC, m_pc);
        cmp({tag, ".pc4"}, PC_PLUS4, exp_p4);
        cmp({tag, ".fv"}, {31'b0, FETCH_VALID}, {31'b0, m_fv});
        cmp({tag, ".flush"}, {31'b0, FLUSH}, {31'b0, m_fl});
        cmp({tag, ".mis"}, {31'b0, MISALIGN}, {31'b0, m_mis});
        cmp({tag, ".state"}, {30'b0, STATE}, 32'(m_mode));
    endtask

    task automatic cyc(input bit bw, input bit hs, input bit bt,
                       input logic [31:0] tgt, input string tag);
        BW = bw;
        HS = hs;
        BT = bt;
        TGT = tgt;
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset");
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h40, "in_reset");
        RESET = 1'b1;

        cyc(0, 0, 1, 32'h80, "boot1");
        cyc(0, 0, 0, 32'h0, "boot2");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 32'h0, "seq");
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 32'h0, "hz_stall");
        cyc(0, 0, 0, 32'h0, "hz_release");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'h0, "busy_stall");
        cyc(0, 0, 0, 32'h0, "busy_release");
        cyc(0, 0, 0, 32'h0, "seq2");
        cyc(0, 0, 0, 32'h0, "seq3");
        cyc(0, 1, 1, 32'h100, "redir_free");
        cyc(0, 0, 0, 32'h0, "after_free");
        cyc(1, 0, 1, 32'h200, "redir_busy1");
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32'h0, "redir_wait");
        cyc(0, 0, 0, 32'h0, "redir_land");
        cyc(0, 0, 1, 32'h103, "misalign");
        cyc(0, 0, 0, 32'h0, "mis_clear");
        cyc(0, 0, 1, 32'h40, "b2b_a");
        cyc(0, 0, 1, 32'h80, "b2b_b");
        cyc(1, 0, 1, 32'h500, "park_a");
        cyc(1, 0, 1, 32'h606, "park_b");
        cyc(0, 0, 0, 32'h0, "park_land");
        cyc(0, 0, 1, 32'hFFFF_FFFC, "to_top");
        cyc(0, 0, 0, 32'h0, "wrap");

        cyc(1, 0, 1, 32'h300, "pre_rst");
        #2;
        RESET = 1'b0;
        model_reset();
        #1;
        check_all("rst_mid");
        cyc(0, 0, 0, 32'h0, "rst_hold");
        RESET = 1'b1;
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 32'h0, "post_rst");

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) == 0, $urandom, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
